scsi_port_sm: RTL

- Peripheral-port cycle engine, downstream of the CPU register decoder.
- Converts a CPU slave access that hits the WD33C93A port window into timed _CSS/_IOR/_IOW strobes on the 8-bit PD bus.
- Returns a port-ready acknowledge that the top level turns into _DSACK.
- Latches read data for the CPU data bus and drives write data plus the PD level-shifter direction.

---
 rtl/scsi_port_sm_if.sv | 30 +++
 rtl/scsi_port_sm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scsi_port_sm_if.sv
// CPU-request and PD-bus bundle for the WD33C93A peripheral port engine.
// slave = the port engine; master = the CPU/peripheral side driving it.
interface scsi_port_sm_if;
    logic       PORT_SEL;
    logic       _AS;
    logic       _DS;
    logic       R_W;
    logic [7:0] DIN;
    logic [7:0] PD_IN;
    logic       _PWAIT;
    logic [7:0] PD_OUT;
    logic       PD_OE;
    logic       _CSS;
    logic       _IOR;
    logic       _IOW;
    logic [7:0] DOUT;
    logic       PORT_ACK;
    logic       BUSY;
    logic       WAIT_TO;

    modport master (
        output PORT_SEL, _AS, _DS, R_W, DIN, PD_IN, _PWAIT,
        input  PD_OUT, PD_OE, _CSS, _IOR, _IOW, DOUT, PORT_ACK, BUSY, WAIT_TO
    );

    modport slave (
        input  PORT_SEL, _AS, _DS, R_W, DIN, PD_IN, _PWAIT,
        output PD_OUT, PD_OE, _CSS, _IOR, _IOW, DOUT, PORT_ACK, BUSY, WAIT_TO
    );
endinterface

// File: rtl/scsi_port_sm.sv
// WD33C93A peripheral-port cycle engine: CPU port-window hit -> timed _CSS/_IOR/_IOW cycle on PD.
// Build option PORT_WAIT_EN: stretch the strobe while _PWAIT is low, bounded, with sticky WAIT_TO.
module scsi_port_sm #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic          SCLK,
    input  logic          _RST,
    scsi_port_sm_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DAT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] REC_LD    = CNT_W'((RECOVERY_CYC == 32'd0) ? 32'd0 : RECOVERY_CYC - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK, S_RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [DAT_W-1:0]   pd_out_q, pd_out_d;
    logic [DAT_W-1:0]   dout_q, dout_d;
    logic               css_n_q, css_n_d;
    logic               ior_n_q, ior_n_d;
    logic               iow_n_q, iow_n_d;
    logic               pd_oe_q, pd_oe_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               start_c;
    logic               abort_c;

`ifdef PORT_WAIT_EN
    localparam int unsigned EXT_W = 8;
    localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(255);
    logic [EXT_W-1:0]   ext_q, ext_d;
    logic               wait_to_q, wait_to_d;
`endif

    assign start_c = bus.PORT_SEL & ~bus._AS & ~bus._DS;
    assign abort_c = bus._AS;

    // Leaving a cycle skips RECOVER entirely when no recovery time is configured.
    function automatic state_t rec_next();
        if (RECOVERY_CYC == 32'd0) return S_IDLE;
        return S_RECOVER;
    endfunction

    // State register plus registered outputs; reset releases every strobe asynchronously.
    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            pd_out_q <= '0;
            dout_q   <= '0;
            css_n_q  <= 1'b1;
            ior_n_q  <= 1'b1;
            iow_n_q  <= 1'b1;
            pd_oe_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PORT_WAIT_EN
            ext_q     <= '0;
            wait_to_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            pd_out_q <= pd_out_d;
            dout_q   <= dout_d;
            css_n_q  <= css_n_d;
            ior_n_q  <= ior_n_d;
            iow_n_q  <= iow_n_d;
            pd_oe_q  <= pd_oe_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
`ifdef PORT_WAIT_EN
            ext_q     <= ext_d;
            wait_to_q <= wait_to_d;
`endif
        end
    end

    // Next state, phase counter and data latches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        pd_out_d = pd_out_q;
        dout_d   = dout_q;
`ifdef PORT_WAIT_EN
        ext_d     = ext_q;
        wait_to_d = wait_to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    rd_d    = bus.R_W;
                    if (!bus.R_W) pd_out_d = bus.DIN;
                end
            end
            S_SETUP: begin
                if (abort_c) begin
                    state_d = rec_next();
                    cnt_d   = REC_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
`ifdef PORT_WAIT_EN
                    ext_d   = '0;
`endif
                end
            end
            S_STROBE: begin
                if (abort_c) begin
                    state_d = rec_next();
                    cnt_d   = REC_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef PORT_WAIT_EN
                end else if (!bus._PWAIT && ext_q != EXT_MAX) begin
                    ext_d = ext_q + EXT_W'(1);
`endif
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    if (rd_q) dout_d = bus.PD_IN;
`ifdef PORT_WAIT_EN
                    if (!bus._PWAIT) wait_to_d = 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (abort_c) begin
                    state_d = rec_next();
                    cnt_d   = REC_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (abort_c) begin
                    state_d = rec_next();
                    cnt_d   = REC_LD;
                end
            end
            S_RECOVER: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; both strobes share one state so they cannot overlap.
    always_comb begin
        css_n_d = 1'b1;
        ior_n_d = 1'b1;
        iow_n_d = 1'b1;
        pd_oe_d = 1'b0;
        ack_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_SETUP, S_HOLD: begin
                css_n_d = 1'b0;
                pd_oe_d = ~rd_d;
            end
            S_STROBE: begin
                css_n_d = 1'b0;
                pd_oe_d = ~rd_d;
                ior_n_d = ~rd_d;
                iow_n_d = rd_d;
            end
            S_ACK:   ack_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.PD_OUT   = pd_out_q;
    assign bus.PD_OE    = pd_oe_q;
    assign bus._CSS     = css_n_q;
    assign bus._IOR     = ior_n_q;
    assign bus._IOW     = iow_n_q;
    assign bus.DOUT     = dout_q;
    assign bus.PORT_ACK = ack_q;
    assign bus.BUSY     = busy_q;

`ifdef PORT_WAIT_EN
    assign bus.WAIT_TO  = wait_to_q;
`else
    logic unused_pwait;
    assign unused_pwait = bus._PWAIT;
    assign bus.WAIT_TO  = 1'b0;
`endif
endmodule
